coor_uart_tx: RTL and testbench

Coordinate frame transmitter and the transmit-side counterpart of the bluetooth coordinate receiver. It takes the `x_coor`/`y_coor` pair produced by the image-processing block, packs it into a 6-byte checksummed frame, and serializes the frame as 8N1 UART on `tx`. The frame format is the one the bluetooth receiver parses, so K210 or a host on the far end receives the FPGA's ball coordinates. The block runs in the `sys_clk` domain; the caller synchronizes `coor_valid_flag` to that domain before it reaches this block.

---
 rtl/coor_uart_if.sv | 20 ++
 rtl/coor_uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_coor_uart_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/coor_uart_if.sv
// Coordinate-in / UART-out bundle shared by the producer and the frame transmitter.
interface coor_uart_if;
  logic [9:0] x_coor;
  logic [9:0] y_coor;
  logic       coor_valid_flag;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [7:0] overrun_cnt;

  modport master (
    output x_coor, y_coor, coor_valid_flag,
    input  tx, busy, frame_done, overrun_cnt
  );

  modport slave (
    input  x_coor, y_coor, coor_valid_flag,
    output tx, busy, frame_done, overrun_cnt
  );
endinterface

// File: rtl/coor_uart_tx.sv
// Packs an x/y coordinate pair into a 6-byte checksummed frame and sends it as 8N1 UART.
module coor_uart_tx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic         clk,
  input  logic         rst,
  coor_uart_if.slave   bus
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [7:0] HDR       = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [7:0]       sum_q, sum_d;
  logic [9:0]       px_q, px_d, py_q, py_d;
  logic             pend_q, pend_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [7:0]       cur_byte_c;
  logic             bit_end_c;
  logic             frame_end_c;
  logic             ovr_inc_c;

  function automatic logic [7:0] frame_sum(input logic [9:0] x, input logic [9:0] y);
    return {6'b0, x[9:8]} + x[7:0] + {6'b0, y[9:8]} + y[7:0];
  endfunction

  // Byte currently on the line, selected from the captured frame registers
  always_comb begin
    case (byte_q)
      3'd0:    cur_byte_c = HDR;
      3'd1:    cur_byte_c = {6'b0, x_q[9:8]};
      3'd2:    cur_byte_c = x_q[7:0];
      3'd3:    cur_byte_c = {6'b0, y_q[9:8]};
      3'd4:    cur_byte_c = y_q[7:0];
      default: cur_byte_c = sum_q;
    endcase
  end

  // Next-state, frame capture, pending buffer and line output
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    x_d       = x_q;
    y_d       = y_q;
    sum_d     = sum_q;
    px_d      = px_q;
    py_d      = py_q;
    pend_d    = pend_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    ovr_inc_c = 1'b0;

    bit_end_c   = (cnt_q == CNT_LAST);
    frame_end_c = (state_q == STOP) && (byte_q == 3'd5) && bit_end_c;

    if (state_q != IDLE) begin
      cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.coor_valid_flag) begin
          x_d     = bus.x_coor;
          y_d     = bus.y_coor;
          sum_d   = frame_sum(bus.x_coor, bus.y_coor);
          byte_d  = 3'd0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          bit_d   = 3'd0;
          tx_d    = cur_byte_c[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte_c[3'(bit_q + 3'd1)];
          end
        end
      end
      STOP: begin
        if (bit_end_c && byte_q != 3'd5) begin
          byte_d  = byte_q + 3'd1;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pulse while busy lands in the one-deep pending slot, newest wins
    if (state_q != IDLE && !frame_end_c && bus.coor_valid_flag) begin
      px_d      = bus.x_coor;
      py_d      = bus.y_coor;
      pend_d    = 1'b1;
      ovr_inc_c = pend_q;
    end

    // End of frame: a same-cycle pulse beats the pending value, which beats idling
    if (frame_end_c) begin
      done_d = 1'b1;
      byte_d = 3'd0;
      if (bus.coor_valid_flag) begin
        x_d       = bus.x_coor;
        y_d       = bus.y_coor;
        sum_d     = frame_sum(bus.x_coor, bus.y_coor);
        pend_d    = 1'b0;
        ovr_inc_c = pend_q;
        tx_d      = 1'b0;
        state_d   = START;
      end else if (pend_q) begin
        x_d     = px_q;
        y_d     = py_q;
        sum_d   = frame_sum(px_q, py_q);
        pend_d  = 1'b0;
        tx_d    = 1'b0;
        state_d = START;
      end else begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    end

    ovr_d  = (ovr_inc_c && ovr_q != 8'hFF) ? ovr_q + 8'd1 : ovr_q;
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset forces the line idle immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pend_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sum_q   <= sum_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pend_q  <= pend_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.overrun_cnt = ovr_q;

endmodule

// File: tb/tb_coor_uart_tx.sv
// Scoreboarded bench: stimulus queues expected bytes, a UART monitor decodes tx and compares.
module tb_coor_uart_tx;

  localparam int unsigned CLK_FREQ = 1_050_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int D   = 10;          // CLK_FREQ/BAUD truncated
  localparam int FRM = 60 * D;

  logic clk;
  logic rst;
  coor_uart_if bus();

  coor_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected bytes for one frame; checksum supplied by hand
  task automatic push_frame(input logic [9:0] x, input logic [9:0] y,
                            input logic [7:0] sum, input int nbytes);
    logic [7:0] b[6];
    b[0] = 8'hA5;
    b[1] = {6'b0, x[9:8]};
    b[2] = x[7:0];
    b[3] = {6'b0, y[9:8]};
    b[4] = y[7:0];
    b[5] = sum;
    for (int i = 0; i < nbytes; i++) exp_q.push_back(b[i]);
  endtask

  // Caller is at a negedge; pulse is sampled at the next posedge, returns one negedge later
  task automatic pulse(input logic [9:0] x, input logic [9:0] y);
    bus.x_coor = x;
    bus.y_coor = y;
    bus.coor_valid_flag = 1'b1;
    @(negedge clk);
    bus.coor_valid_flag = 1'b0;
  endtask

  // Count negedges until frame_done, then check latency and what follows
  task automatic wait_done(input string nm, input int exp_n, input bit exp_busy);
    int n = 0;
    int gaps = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.busy && !bus.frame_done) gaps++;
    end while (!bus.frame_done && n < FRM + 10 * D);
    chk({nm, "_done_latency"}, n, exp_n);
    chk({nm, "_busy_gap"}, gaps, 0);
    chk({nm, "_busy_after"}, int'(bus.busy), int'(exp_busy));
    chk({nm, "_tx_after"}, int'(bus.tx), int'(!exp_busy));
    @(negedge clk);
    chk({nm, "_done_width"}, int'(bus.frame_done), 0);
  endtask

  // UART monitor: samples each bit mid-cell, pops and compares each decoded byte
  int         m_cnt = 0;
  bit         m_act = 1'b0;
  logic [9:0] m_sh  = '0;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_act = 1'b0;
    end else begin
      if (!m_act && bus.tx == 1'b0) begin
        m_act = 1'b1;
        m_cnt = 0;
      end else if (m_act) begin
        m_cnt++;
      end
      if (m_act && (m_cnt % D) == D / 2) begin
        m_sh[m_cnt / D] = bus.tx;
        if (m_cnt / D == 9) begin
          m_act = 1'b0;
          chk("stop_bit", int'(m_sh[9]), 1);
          if (exp_q.size() == 0) chk("unexpected_byte", int'(m_sh[8:1]), -1);
          else chk("rx_byte", int'(m_sh[8:1]), int'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.x_coor = '0;
    bus.y_coor = '0;
    bus.coor_valid_flag = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(bus.tx), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.frame_done), 0);
    chk("rst_ovr", int'(bus.overrun_cnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame: A5 01 55 00 F0 46
    push_frame(10'd341, 10'd240, 8'h46, 6);
    pulse(10'd341, 10'd240);
    chk("single_tx_fall", int'(bus.tx), 0);
    chk("single_busy_rise", int'(bus.busy), 1);
    wait_done("single", FRM, 1'b0);
    chk("single_ovr", int'(bus.overrun_cnt), 0);

    // Boundary values, checksum wrap and all-zero frame
    push_frame(10'd1023, 10'd0, 8'h02, 6);
    pulse(10'd1023, 10'd0);
    wait_done("x1023", FRM, 1'b0);
    push_frame(10'd0, 10'd0, 8'h00, 6);
    pulse(10'd0, 10'd0);
    wait_done("zero", FRM, 1'b0);

    // Pending overwrite: (2,2) replaced by (3,3), back-to-back frames
    push_frame(10'd1, 10'd1, 8'h02, 6);
    push_frame(10'd3, 10'd3, 8'h06, 6);
    pulse(10'd1, 10'd1);
    repeat (10) @(negedge clk);
    pulse(10'd2, 10'd2);
    repeat (5) @(negedge clk);
    pulse(10'd3, 10'd3);
    wait_done("pend_f1", FRM - 17, 1'b1);
    chk("pend_ovr", int'(bus.overrun_cnt), 1);
    wait_done("pend_f2", FRM - 1, 1'b0);

    // Pulse in the last stop cycle beats pending (5,5)
    push_frame(10'd4, 10'd4, 8'h08, 6);
    push_frame(10'd6, 10'd6, 8'h0C, 6);
    pulse(10'd4, 10'd4);
    pulse(10'd5, 10'd5);
    repeat (FRM - 2) @(negedge clk);
    pulse(10'd6, 10'd6);
    chk("simul_done", int'(bus.frame_done), 1);
    chk("simul_tx", int'(bus.tx), 0);
    chk("simul_ovr", int'(bus.overrun_cnt), 2);
    wait_done("simul_f2", FRM, 1'b0);

    // Saturation: 300 pulses during one frame
    push_frame(10'd7, 10'd7, 8'h0E, 6);
    push_frame(10'h2AA, 10'h155, 8'h02, 6);
    pulse(10'd7, 10'd7);
    for (int i = 0; i < 299; i++) pulse(10'd9, 10'd9);
    pulse(10'h2AA, 10'h155);
    chk("sat_ovr", int'(bus.overrun_cnt), 255);
    wait_done("sat_f1", FRM - 300, 1'b1);
    wait_done("sat_f2", FRM - 1, 1'b0);
    chk("sat_ovr_hold", int'(bus.overrun_cnt), 255);

    // Reset during B3 with a pending value queued
    push_frame(10'h123, 10'h321, 8'h48, 3);
    pulse(10'h123, 10'h321);
    pulse(10'h3FF, 10'h3FF);
    repeat (33 * D) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", int'(bus.tx), 1);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_ovr", int'(bus.overrun_cnt), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5 * D) @(negedge clk);
    chk("postrst_idle_tx", int'(bus.tx), 1);
    chk("postrst_idle_busy", int'(bus.busy), 0);
    push_frame(10'h0AB, 10'h201, 8'hAE, 6);
    pulse(10'h0AB, 10'h201);
    wait_done("postrst", FRM, 1'b0);
    repeat (20 * D) @(negedge clk);
    chk("postrst_no_stale", int'(bus.busy), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
